// File: rtl/radio_timing_sequencer_pkg.sv
// pk_TimingEngine: definitions shared by the radio timing sequencer and its
// input synchronizers.
//   state_t          : sequencer FSM states
//   SYNC_STAGE_FIRST : index of the synchronizer flop that samples the raw input
//   SYNC_STAGE_LAST  : index of the synchronizer flop that drives the output
package pk_TimingEngine;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PLL = 2'd1,
        SETTLE   = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    localparam int unsigned SYNC_STAGE_FIRST = 0;
    localparam int unsigned SYNC_STAGE_LAST  = 1;

endpackage

// File: rtl/radio_timing_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single-bit level signal.
//   clk     : destination clock
//   rst     : synchronous active-high reset, clears both flops
//   async_i : unsynchronised input
//   sync_o  : async_i as sampled two rising edges earlier
module sync_2ff
    import pk_TimingEngine::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGE_LAST:SYNC_STAGE_FIRST] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE_FIRST], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGE_LAST];

endmodule

// File: rtl/radio_timing_sequencer.sv
// radio_timing_sequencer: brings the radio up once the PLL is locked and has
// been stable for tArstFs cycles, and drops it on request or on loss of lock.
//   clk                 : clock, rising edge
//   rst                 : synchronous active-high reset
//   radioEnableUnsynced : enable request (asynchronous source)
//   radioRxEnUnsynced   : RX(1)/TX(0) mode request (asynchronous source)
//   pllSettled          : PLL lock, clk domain
//   tArstFs             : settle time in clk cycles (0 = no settle phase)
//   radioEnableSynced   : synchronised enable request
//   radioRxEnSynced     : synchronised mode request
//   radioEnable         : high while the sequencer is ACTIVE
//   radioRxEn           : RX select, forced low outside ACTIVE
//   busy                : high while the sequencer is not IDLE
//   pllLost             : one-cycle pulse when lock drops during ACTIVE
module radio_timing_sequencer
    import pk_TimingEngine::*;
#(
    parameter int unsigned SIZE_SPISLAVE_T_ARSTFS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              radioEnableUnsynced,
    input  logic                              radioRxEnUnsynced,
    input  logic                              pllSettled,
    input  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs,
    output logic                              radioEnableSynced,
    output logic                              radioRxEnSynced,
    output logic                              radioEnable,
    output logic                              radioRxEn,
    output logic                              busy,
    output logic                              pllLost
);

    localparam logic [SIZE_SPISLAVE_T_ARSTFS-1:0] CNT_ONE = SIZE_SPISLAVE_T_ARSTFS'(1);

    state_t                            state_q, state_d;
    logic [SIZE_SPISLAVE_T_ARSTFS-1:0] cnt_q, cnt_d;
    logic                              lost_d;
    logic                              radio_enable_q, radio_rx_en_q, busy_q, pll_lost_q;

    sync_2ff u_sync_enable (
        .clk     (clk),
        .rst     (rst),
        .async_i (radioEnableUnsynced),
        .sync_o  (radioEnableSynced)
    );

    sync_2ff u_sync_rx_en (
        .clk     (clk),
        .rst     (rst),
        .async_i (radioRxEnUnsynced),
        .sync_o  (radioRxEnSynced)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (radioEnableSynced) begin
                    state_d = WAIT_PLL;
                end
            end
            WAIT_PLL: begin
                if (!radioEnableSynced) begin
                    state_d = IDLE;
                end else if (pllSettled) begin
                    if (tArstFs == '0) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = tArstFs;
                    end
                end
            end
            SETTLE: begin
                // The counter is never zero here (a zero settle time bypasses
                // SETTLE), but <= keeps it from wrapping regardless.
                if (!radioEnableSynced) begin
                    state_d = IDLE;
                end else if (!pllSettled) begin
                    state_d = WAIT_PLL;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACTIVE: begin
                if (!radioEnableSynced) begin
                    state_d = IDLE;
                end else if (!pllSettled) begin
                    state_d = WAIT_PLL;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // cycles in which the state register holds the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            radio_enable_q <= 1'b0;
            radio_rx_en_q  <= 1'b0;
            busy_q         <= 1'b0;
            pll_lost_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            radio_enable_q <= (state_d == ACTIVE);
            radio_rx_en_q  <= (state_d == ACTIVE) && radioRxEnSynced;
            busy_q         <= (state_d != IDLE);
            pll_lost_q     <= lost_d;
        end
    end

    assign radioEnable = radio_enable_q;
    assign radioRxEn   = radio_rx_en_q;
    assign busy        = busy_q;
    assign pllLost     = pll_lost_q;

endmodule

// File: doc/radio_timing_sequencer.md
RADIO_TIMING_SEQUENCER -- requirements
Module: radio_timing_sequencer

Interface
REQ-001 SHALL have parameter SIZE_SPISLAVE_T_ARSTFS, default 1, giving the width of the settle-time count tArstFs.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port radioEnableUnsynced, input, 1, radio enable request from an unsynchronised source.
REQ-005 SHALL have port radioRxEnUnsynced, input, 1, RX (1) / TX (0) mode request, unsynchronised.
REQ-006 SHALL have port pllSettled, input, 1, PLL lock indication, already in the clk domain.
REQ-007 SHALL have port tArstFs, input, SIZE_SPISLAVE_T_ARSTFS, settle time in clk cycles.
REQ-008 SHALL have port radioEnableSynced, output, 1, synchronised radioEnableUnsynced.
REQ-009 SHALL have port radioRxEnSynced, output, 1, synchronised radioRxEnUnsynced.
REQ-010 SHALL have port radioEnable, output, 1, radio datapath enable.
REQ-011 SHALL have port radioRxEn, output, 1, radio RX mode select, qualified by radioEnable.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 SHALL have port pllLost, output, 1, single-cycle pulse when lock is lost while in ACTIVE.

Function
REQ-014 SHALL pass each Unsynced input through its own two-flop synchronizer; the Synced output equals the input sampled two edges earlier.
REQ-015 SHALL implement an FSM with exactly four states: IDLE, WAIT_PLL, SETTLE, ACTIVE.
REQ-016 In IDLE, the FSM SHALL go to WAIT_PLL when radioEnableSynced=1; otherwise it SHALL stay in IDLE.
REQ-017 In WAIT_PLL, the transitions SHALL be, in priority order:
- radioEnableSynced=0 -> IDLE.
- pllSettled=1 and tArstFs=0 -> ACTIVE.
- pllSettled=1 -> SETTLE, with the counter loaded from tArstFs.
REQ-018 The counter SHALL be SIZE_SPISLAVE_T_ARSTFS wide and SHALL be loaded only on entry to SETTLE; later tArstFs changes are ignored until the next entry.
REQ-019 In SETTLE, the transitions SHALL be, in priority order:
- radioEnableSynced=0 -> IDLE.
- pllSettled=0 -> WAIT_PLL.
- counter=1 -> ACTIVE.
- otherwise, decrement the counter and stay.
- Net effect: SETTLE lasts exactly tArstFs cycles; the counter never wraps.
REQ-020 In ACTIVE, the transitions SHALL be, in priority order:
- radioEnableSynced=0 -> IDLE.
- pllSettled=0 -> WAIT_PLL, with pllLost=1 for that one cycle.
REQ-021 radioEnable SHALL be a registered output, high exactly in the cycles in which the state register holds ACTIVE.
REQ-022 radioRxEn SHALL be registered, equal to radioRxEnSynced while in ACTIVE, and 0 otherwise; mode changes during ACTIVE propagate with 1 cycle of latency.
REQ-023 Timing: radioEnableUnsynced first sampled high at edge k, with pllSettled=1 throughout, SHALL give radioEnable=1 from edge k+3+tArstFs.
REQ-024 When radioEnableSynced falls, radioEnable and radioRxEn SHALL be 0 from the next edge.
REQ-025 The abort path (radioEnableSynced=0) SHALL take priority over the pllSettled path whenever both events occur in the same cycle.

Reset
REQ-026 rst=1 SHALL set the following, from the next edge, regardless of state:
- all synchronizer flops to 0;
- state to IDLE;
- counter to 0;
- radioEnable, radioRxEn, busy and pllLost to 0.
REQ-027 Reset asserted mid-SETTLE or mid-ACTIVE SHALL drop radioEnable at the next edge with no pllLost pulse.
REQ-028 After rst falls, the block SHALL need a fresh synchronised radioEnable request before leaving IDLE.

Structure
REQ-029 The state enum and the two synchronizer stage constants SHALL be in shared package pk_TimingEngine.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, instantiated once per Unsynced input.
REQ-031 The FSM, counter and output registers SHALL be in radio_timing_sequencer, sized to implement in 120-400 lines.

Verification
REQ-032 With pllSettled=1, tArstFs=4, raise radioEnableUnsynced at edge 10 -> radioEnable rises at edge 17, and busy is high from edge 12.
REQ-033 With tArstFs=0, pllSettled=1 -> radioEnable rises 3 edges after the request is sampled, and SETTLE is never visited.
REQ-034 With tArstFs=5, drop pllSettled in the 3rd SETTLE cycle and restore it 2 cycles later -> FSM returns to WAIT_PLL, reloads 5, and radioEnable is delayed accordingly.
REQ-035 In ACTIVE with radioRxEnUnsynced=1, drop pllSettled for 1 cycle -> exactly one pllLost pulse, radioEnable=0 for 1+tArstFs cycles, then ACTIVE again with radioRxEn=1.
REQ-036 In the same cycle, drop radioEnableSynced and pllSettled while in ACTIVE -> IDLE, no pllLost pulse.
REQ-037 Assert rst for 1 cycle during ACTIVE -> all outputs 0 at the next edge; with the request still high, re-entry to ACTIVE occurs after 3+tArstFs edges.
